bit_serial_or: RTL

BIT_SERIAL_OR -- requirements
Module: bit_serial_or

---
 rtl/bit_serial_or_pkg.sv | 10 +
 rtl/bit_serial_or_cell.sv | 10 +
 rtl/bit_serial_or.sv | 84 ++++++++
 3 files changed

// File: rtl/bit_serial_or_pkg.sv
// Shared definitions for the bit-serial OR engine: default width and FSM state codes.
package bit_serial_or_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bit_serial_or_cell.sv
// 1-bit OR cell; the serial engine pushes one operand bit pair through it per cycle.
module bit_serial_or_cell (
    input  logic a,
    input  logic b,
    output logic res
);

    assign res = a | b;

endmodule

// File: rtl/bit_serial_or.sv
// Bit-serial a|b: operands are shifted LSB-first through a single 1-bit OR cell,
// one bit per cycle, and the finished word is published with a one-cycle done pulse.
module bit_serial_or
    import bit_serial_or_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             nonzero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [CNT_W-1:0] cnt;
    logic             or_bit;

    bit_serial_or_cell u_or_cell (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .res (or_bit)
    );

    // Result bits enter at the MSB, so after WIDTH shifts bit i lands in position i.
    assign work_next = {or_bit, work[WIDTH-1:1]};

    // The final RUN edge publishes work_next directly so res is valid during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            work    <= '0;
            cnt     <= '0;
            res     <= '0;
            nonzero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        work  <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work <= work_next;
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        res     <= work_next;
                        nonzero <= |work_next;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

endmodule
